// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// CSUM_W sizes the optional trailing checksum (IMEM_LOADER_CHECKSUM_EN).
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int CSUM_W         = 8;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    // Modulo-2**CSUM_W running sum of data bytes.
    function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] sum,
                                                   input logic [7:0]        b);
        return sum + b;
    endfunction

endpackage

// File: rtl/imem_loader_asm.sv
// Byte-to-word assembler: shifts accepted bytes in big-endian order and counts
// bytes within the current word.
module imem_loader_asm
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [7:0]        byte_i,
    output logic              last_byte_o,
    output logic [WORD_W-1:0] word_o
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    assign last_byte_o = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
    assign word_o      = word_q;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (accept_i) begin
            cnt_d  = last_byte_o ? '0 : cnt_q + 1'b1;
            word_d = {word_q[WORD_W-9:0], byte_i};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams bytes into 32-bit instruction words and holds the CPU in
// reset until the image is written. Define IMEM_LOADER_CHECKSUM_EN for a trailing checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   idx_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              byte_ready_q, imem_we_q, busy_q, done_q, cpu_hold_q;
    logic              accept, asm_clear, asm_accept, last_byte;
    logic [WORD_W-1:0] asm_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] sum_q, sum_d;
    logic              err_q;
`endif

    assign accept     = byte_valid && byte_ready_q;
    assign asm_accept = accept && (state_q == ST_LOAD);
    assign idx_inc    = idx_q + 1'b1;

    imem_loader_asm u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (asm_clear),
        .accept_i   (asm_accept),
        .byte_i     (byte_in),
        .last_byte_o(last_byte),
        .word_o     (asm_word)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        count_d   = count_q;
        addr_d    = addr_q;
        asm_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (start) begin
                    if (word_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_LOAD;
                        idx_d     = '0;
                        count_d   = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
                        asm_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d     = '0;
`endif
                    end
                end
            end
            ST_LOAD: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) sum_d = csum_add(sum_q, byte_in);
`endif
                if (accept && last_byte) begin
                    state_d = ST_WRITE;
                    addr_d  = idx_q[ADDR_W-1:0];
                end
            end
            ST_WRITE: begin
                // Clamped count keeps idx_q below 2**ADDR_W while writing, so the address never wraps.
                idx_d = idx_inc;
                if (idx_inc == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (accept) state_d = (byte_in == sum_q) ? ST_DONE : ST_FAIL;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cpu_hold_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            byte_ready_q <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
            imem_we_q    <= (state_d == ST_WRITE);
            busy_q       <= (state_d == ST_LOAD) || (state_d == ST_WRITE) || (state_d == ST_CHECK);
            done_q       <= (state_d == ST_DONE);
            cpu_hold_q   <= (state_d != ST_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
            err_q        <= (state_d == ST_FAIL);
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = asm_word;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cpu_hold   = cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the instruction-memory word-address width.
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, level sampled per cycle; requests a program load.
REQ-005 The block SHALL have port word_count, input, ADDR_W+1, number of 32-bit words to load, sampled when a load is accepted.
REQ-006 The block SHALL have port byte_in, input, 8, serial program byte.
REQ-007 The block SHALL have port byte_valid, input, 1, byte_in is valid.
REQ-008 The block SHALL have port byte_ready, output, 1, loader accepts byte_in this cycle.
REQ-009 The block SHALL have ports imem_we (output, 1), imem_addr (output, ADDR_W) and imem_wdata (output, 32), forming the instruction-memory write port.
REQ-010 The block SHALL have ports cpu_hold (output, 1), busy (output, 1), done (output, 1) and err (output, 1); cpu_hold=1 keeps the CPU core in reset.

Function
REQ-011 States SHALL be IDLE, LOAD, WRITE, CHECK, DONE and FAIL.
REQ-012 A byte SHALL be accepted only in a cycle with byte_valid=1 and byte_ready=1, and byte_ready SHALL be 1 only in LOAD and CHECK.
REQ-013 In LOAD, bytes SHALL be assembled big-endian (first byte to bits 31:24), and the 4th accepted byte SHALL move the FSM to WRITE on the next edge.
REQ-014 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr=current word index and imem_wdata=the assembled word.
REQ-015 After WRITE, the word index SHALL increment; if it then equals word_count, the FSM SHALL go to CHECK (macro defined) or DONE, otherwise back to LOAD.
REQ-016 In IDLE or DONE, start=1 with word_count=0 SHALL go directly to DONE; start=1 with word_count>0 SHALL clear the index and byte counter and go to LOAD.
REQ-017 start SHALL be ignored in LOAD, WRITE and CHECK.
REQ-018 word_count values above 2**ADDR_W SHALL be clamped to 2**ADDR_W, and imem_addr SHALL never wrap within one load.
REQ-019 busy SHALL be 1 exactly in LOAD, WRITE and CHECK; done SHALL be 1 only in DONE; cpu_hold SHALL be 0 only in DONE.
REQ-020 imem_we SHALL be 0 in all states except WRITE.

Reset
REQ-021 On reset=0, the block SHALL asynchronously enter IDLE with byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, err=0, and cleared counters and checksum.
REQ-022 Reset asserted mid-load SHALL abandon the load with no further imem_we pulse.

Configuration
REQ-023 With macro IMEM_LOADER_CHECKSUM_EN defined, the block SHALL keep an 8-bit modulo-256 sum of all data bytes, accept one trailing byte in CHECK, and go to DONE on match or to FAIL with err=1 on mismatch.
REQ-024 FAIL SHALL keep cpu_hold=1 and SHALL accept start exactly as IDLE does; err SHALL clear when a new load is accepted.
REQ-025 Without the macro, CHECK and FAIL SHALL be unreachable and err SHALL be tied to 0.

Structure
REQ-026 Package imem_loader_pkg SHALL hold the state enumeration, the byte-per-word constant (4) and the checksum width (8).
REQ-027 The byte-to-word shifter and byte counter SHALL be a sub-module, imem_loader_asm.

Verification
REQ-028 Load test: word_count=2 with bytes 3C,08,00,01,8D,09,00,04 -> imem_we pulses write 3C080001 to address 0 and 8D090004 to address 1; done=1 and cpu_hold=0 one cycle after the second WRITE.
REQ-029 Backpressure test: byte_valid toggled every other cycle -> identical words and addresses, and no byte is accepted during WRITE.
REQ-030 Zero-length test: start with word_count=0 -> DONE on the next edge with no imem_we pulse.
REQ-031 Mid-load reset test: reset=0 after 6 bytes of a 4-word load -> immediate IDLE, cpu_hold=1, and no further writes.
REQ-032 Checksum test (macro defined): bytes 01,02,03,04 followed by trailing byte 0A -> DONE; trailing byte 0B -> FAIL with err=1 and cpu_hold=1.
REQ-033 Restart and clamp test: start asserted in DONE reloads and sets cpu_hold=1; word_count=2**ADDR_W+5 loads exactly 2**ADDR_W words, with a final address of 2**ADDR_W-1.
